// File: rtl/instr_fetch_if.sv
// Instruction fetch bus: program control, instruction memory port
// and decoder-side FWFT instruction stream.
interface instr_fetch_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) ();
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [ADDR_WIDTH:0]   i_num_instr;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_imem_read_req;
    logic [ADDR_WIDTH-1:0] o_imem_read_addr;
    logic [DATA_WIDTH-1:0] i_imem_read_data;
    logic                  o_instr_valid;
    logic [DATA_WIDTH-1:0] o_instr_data;
    logic                  i_instr_ready;

    modport slave (
        input  i_start, i_base_addr, i_num_instr,
        input  i_imem_read_data, i_instr_ready,
        output o_busy, o_done,
        output o_imem_read_req, o_imem_read_addr,
        output o_instr_valid, o_instr_data
    );

    modport master (
        output i_start, i_base_addr, i_num_instr,
        output i_imem_read_data, i_instr_ready,
        input  o_busy, o_done,
        input  o_imem_read_req, o_imem_read_addr,
        input  o_instr_valid, o_instr_data
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetcher: streams a program from instruction memory
// into a small FWFT buffer, issuing reads only when space is assured.
module instr_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7,
    parameter int FIFO_DEPTH = 4
) (
    input logic          clk,
    input logic          reset,
    instr_fetch_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int NW = ADDR_WIDTH + 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [NW-1:0]         num;
    logic [NW-1:0]         issued;
    logic [NW-1:0]         popped;
    logic                  inflight;
    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  credit;
    logic                  req;
    logic                  push;
    logic                  pop;

    // Returned data cannot be refused, so a read needs a free slot
    // that is not already promised to a read in flight.
    assign credit = ({1'b0, count} + {{CW{1'b0}}, inflight})
                    < (CW+1)'(FIFO_DEPTH);
    assign req    = (state == FETCH) && (issued != num) && credit;
    assign push   = inflight;
    assign pop    = (count != '0) && bus.i_instr_ready;

    assign bus.o_busy           = (state != IDLE);
    assign bus.o_done           = (state == DONE);
    assign bus.o_imem_read_req  = req;
    assign bus.o_imem_read_addr = addr;
    assign bus.o_instr_valid    = (count != '0);
    assign bus.o_instr_data     = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            addr   <= '0;
            num    <= '0;
            issued <= '0;
            popped <= '0;
        end else begin
            if (pop)
                popped <= popped + NW'(1);
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        addr   <= bus.i_base_addr;
                        num    <= bus.i_num_instr;
                        issued <= '0;
                        popped <= '0;
                        state  <= (bus.i_num_instr == '0) ? DONE : FETCH;
                    end
                end
                FETCH: begin
                    if (req) begin
                        addr   <= addr + ADDR_WIDTH'(1);
                        issued <= issued + NW'(1);
                        if (issued + NW'(1) == num)
                            state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (!inflight && count == '0 && popped == num)
                        state <= DONE;
                end
                DONE: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= req;
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop)
                rd_ptr <= rd_ptr + PW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= bus.i_imem_read_data;
    end
endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, which is the instruction word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 7, which is the instruction memory word-address width (128 words).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, which is the output buffer depth in words; legal values are powers of two and at least 2.
REQ-004 Clock and reset: one clock; reset is asynchronous and active-high; port clk is the clock and port reset is the reset.
REQ-005 SHALL have port clk, input, width 1: rising-edge clock.
REQ-006 SHALL have port reset, input, width 1: asynchronous active-high reset.
REQ-007 SHALL have port i_start, input, width 1: single-cycle request to begin fetching a program.
REQ-008 SHALL have port i_base_addr, input, width ADDR_WIDTH: first instruction address, sampled on an accepted i_start.
REQ-009 SHALL have port i_num_instr, input, width ADDR_WIDTH+1: instruction count, sampled on an accepted i_start.
REQ-010 SHALL have port o_busy, output, width 1: high from an accepted start until done.
REQ-011 SHALL have port o_done, output, width 1: one-cycle completion pulse.
REQ-012 SHALL have port o_imem_read_req, output, width 1: read strobe to the instruction memory.
REQ-013 SHALL have port o_imem_read_addr, output, width ADDR_WIDTH: read address to the instruction memory.
REQ-014 SHALL have port i_imem_read_data, input, width DATA_WIDTH: memory data, valid exactly one cycle after o_imem_read_req and undefined/Z otherwise.
REQ-015 SHALL have port o_instr_valid, output, width 1: head of the output buffer is valid.
REQ-016 SHALL have port o_instr_data, output, width DATA_WIDTH: instruction word at the buffer head.
REQ-017 SHALL have port i_instr_ready, input, width 1: decoder accepts o_instr_data.

Function
REQ-018 SHALL implement states IDLE, FETCH, DRAIN and DONE.
REQ-019 Transitions: IDLE->FETCH on i_start; FETCH->DRAIN once i_num_instr reads have been issued; DRAIN->DONE when no read is in flight, the buffer is empty and the last word has been popped; DONE->IDLE after exactly one cycle.
REQ-020 i_start SHALL be accepted only in IDLE; i_start in any other state SHALL be ignored.
REQ-021 i_start with i_num_instr=0 SHALL go to DONE with no memory reads, giving o_done high in the cycle after the start edge.
REQ-022 o_busy SHALL be high in FETCH, DRAIN and DONE, and low in IDLE.
REQ-023 o_done SHALL be high only in DONE.
REQ-024 o_imem_read_req SHALL be asserted only in FETCH, and only when (buffer occupancy + reads in flight) < FIFO_DEPTH.
REQ-025 This credit rule SHALL prevent overflow, because returned data can never be refused.
REQ-026 The first read SHALL use address i_base_addr; each issued read SHALL increment the address by 1 modulo 2^ADDR_WIDTH (127 wraps to 0).
REQ-027 o_imem_read_addr SHALL be held stable while o_imem_read_req is low.
REQ-028 A one-bit in-flight flag, registered from o_imem_read_req, SHALL qualify capture of i_imem_read_data.
REQ-029 i_imem_read_data SHALL never be sampled in a cycle where that in-flight flag is low.
REQ-030 The output buffer SHALL be first-word-fall-through.
REQ-031 o_instr_valid SHALL equal "buffer not empty", and o_instr_data SHALL equal the buffer head.
REQ-032 A pop SHALL occur when o_instr_valid and i_instr_ready are both high.
REQ-033 A simultaneous push and pop SHALL be permitted and leave occupancy unchanged.
REQ-034 Pop on empty and push on full SHALL be impossible by construction.
REQ-035 Latency from start to first instruction: start accepted at edge E0; read_req high after E0; memory data present after E1; word pushed at E2; o_instr_valid high after E2.
REQ-036 With i_instr_ready held high, the block SHALL sustain one instruction per cycle after the first.
REQ-037 Back-pressure on i_instr_ready SHALL stall reads via the credit rule and SHALL NOT drop or reorder words.
REQ-038 Counters for issued and popped instructions SHALL be ADDR_WIDTH+1 bits so that a full count of 2^ADDR_WIDTH is representable.

Reset
REQ-039 While reset is asserted, the block SHALL be in IDLE.
REQ-040 While reset is asserted, the outputs SHALL be: o_busy=0, o_done=0, o_imem_read_req=0, o_imem_read_addr=0, o_instr_valid=0, o_instr_data=0.
REQ-041 While reset is asserted, the buffer pointers, counters and in-flight flag SHALL be 0.
REQ-042 Reset mid-operation SHALL abandon the program and discard any buffered or in-flight words.
REQ-043 Memory data that returns after reset is released SHALL be ignored.

Verification
REQ-044 Bench SHALL cover: start, base=5, num=3, ready held 1 -> reads at addresses 5,6,7 on consecutive cycles; data out in order on 3 consecutive cycles; first o_instr_valid 2 cycles after the first read_req; o_done pulses once.
REQ-045 Bench SHALL cover: base=126, num=4 -> read addresses 126,127,0,1.
REQ-046 Bench SHALL cover: num=10, ready held 0 -> exactly 4 reads issued and then read_req stays 0; after ready rises, all 10 words are delivered in order with no loss.
REQ-047 Bench SHALL cover: num=0 -> o_done high the cycle after start, no read_req, o_busy high for exactly 1 cycle.
REQ-048 Bench SHALL cover: second i_start during FETCH -> ignored, and the original program completes unchanged.
REQ-049 Bench SHALL cover: reset asserted 1 cycle after the first read_req -> all outputs 0 immediately, o_instr_valid stays 0 after release, and a new start with base=0, num=2 works normally.
